led_matrix_scanner: RTL and testbench

//   Parametrised multi-panel LED matrix driver: NUM_PANELS panels of ROWS x COLS LEDs share row lines, each with its own column lines.
//   A serial bit stream fills a shadow frame buffer. A commit request swaps it into the display buffer only at a frame boundary, so there is no tearing.
//   A scan engine time-multiplexes panels and columns, with a programmable blanking gap between slots for ghost suppression.

---
 rtl/led_matrix_scanner.sv | 190 +++++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: serial-loaded, double-buffered multi-panel LED matrix
// scanner. A shadow buffer is filled bit by bit and swapped into the display
// buffer only at a frame boundary; the scan engine walks (column, panel)
// slots and inserts a blank gap before each slot to suppress ghosting.
module led_matrix_scanner #(
  parameter int NUM_PANELS   = 2,
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sh_valid,
  input  logic                       sh_data,
  input  logic                       commit,
  output logic                       busy,
  output logic                       frame_err,
  output logic                       frame_start,
  output logic [ROWS-1:0]            row,
  output logic [NUM_PANELS*COLS-1:0] col
);

  localparam int B          = COLS * (ROWS + 1);
  localparam int FRAME_BITS = NUM_PANELS * B;
  localparam int NCOL       = NUM_PANELS * COLS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int TMR_MAX    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int C_W        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int P_W        = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Frame buffers and load control
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic [FRAME_BITS-1:0] display_q, display_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  frame_start_q, frame_start_d;

  // Scan engine
  state_t                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [C_W-1:0]        c_q, c_d;
  logic [P_W-1:0]        p_q, p_d;
  logic                  frame_end;

  // Registered drive outputs
  logic [ROWS-1:0]       row_q, row_d;
  logic [NCOL-1:0]       col_q, col_d;

  // Display buffer unpacked per slot
  logic [ROWS-1:0]       slot_rows [NUM_PANELS][COLS];
  logic [NCOL-1:0]       col_sel;

  // Panel p occupies the block shifted in p-th; inside a block the column
  // enables come first, then the row bytes for column 0 .. COLS-1.
  for (genvar gi = 0; gi < NUM_PANELS; gi++) begin : g_panel
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      assign slot_rows[gi][gj] =
        display_q[(NUM_PANELS-1-gi)*B + (COLS-1-gj)*ROWS +: ROWS];
      assign col_sel[gi*COLS + gj] =
        (state_q == ST_DRIVE) && (p_q == P_W'(gi)) && (c_q == C_W'(gj)) &&
        display_q[(NUM_PANELS-1-gi)*B + B - COLS + gj];
    end
  end

  // Slot timing: blank gap, then dwell; panel is the inner counter
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    c_d       = c_q;
    p_d       = p_q;
    frame_end = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (tmr_q == TMR_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_DRIVE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (tmr_q == TMR_W'(DWELL_CYCLES - 1)) begin
          state_d = ST_BLANK;
          tmr_d   = '0;
          if (p_q == P_W'(NUM_PANELS - 1)) begin
            p_d = '0;
            if (c_q == C_W'(COLS - 1)) begin
              c_d       = '0;
              frame_end = 1'b1;
            end else begin
              c_d = c_q + 1'b1;
            end
          end else begin
            p_d = p_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Shadow loading, commit handshake and the tear-free swap at frame end
  always_comb begin
    shadow_d      = shadow_q;
    display_d     = display_q;
    count_d       = count_q;
    busy_d        = busy_q;
    frame_err_d   = 1'b0;
    frame_start_d = 1'b0;
    if (busy_q) begin
      // Loading is frozen while a frame waits for the boundary.
      if (frame_end) begin
        display_d     = shadow_q;
        busy_d        = 1'b0;
        frame_start_d = 1'b1;
      end
    end else if (commit) begin
      // Commit wins over a same-cycle shift; that bit is discarded.
      count_d = '0;
      if (count_q == CNT_W'(FRAME_BITS)) begin
        busy_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end else if (sh_valid) begin
      shadow_d = {shadow_q[FRAME_BITS-2:0], sh_data};
      // FRAME_BITS+1 marks an over-long load and is held there.
      if (count_q != CNT_W'(FRAME_BITS + 1)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Drive values for the current slot, registered below (one-cycle latency)
  always_comb begin
    row_d = '0;
    col_d = col_sel;
    if (state_q == ST_DRIVE) begin
      row_d = slot_rows[p_q][c_q];
    end
  end

  // All state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q      <= '0;
      display_q     <= '0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_start_q <= 1'b0;
      state_q       <= ST_BLANK;
      tmr_q         <= '0;
      c_q           <= '0;
      p_q           <= '0;
      row_q         <= '0;
      col_q         <= '0;
    end else begin
      shadow_q      <= shadow_d;
      display_q     <= display_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
      frame_start_q <= frame_start_d;
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      c_q           <= c_d;
      p_q           <= p_d;
      row_q         <= row_d;
      col_q         <= col_d;
    end
  end

  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign frame_start = frame_start_q;
  assign row         = row_q;
  assign col         = col_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner (2 panels of 8x8, dwell 4, blank 2).
module tb_led_matrix_scanner;

  localparam int NP    = 2;
  localparam int R     = 8;
  localparam int C     = 8;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int FB    = NP * C * (R + 1);   // 144
  localparam int SLOT  = BL + DW;            // 6
  localparam int FRAME = NP * C * SLOT;      // 96

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sh_valid = 1'b0;
  logic        sh_data = 1'b0;
  logic        commit = 1'b0;
  logic        busy, frame_err, frame_start;
  logic [7:0]  row;
  logic [15:0] col;

  int n_vec = 0;
  int n_err = 0;
  int fc = 0;   // frame cycle the DUT scan is in during the current cycle

  // Loaded frame (m_*) and frame expected on the display (d_*)
  logic [7:0] m_en   [NP];
  logic [7:0] m_rows [NP][C];
  logic [7:0] d_en   [NP];
  logic [7:0] d_rows [NP][C];
  logic [FB-1:0] vec;

  led_matrix_scanner #(
    .NUM_PANELS  (NP),
    .ROWS        (R),
    .COLS        (C),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sh_valid   (sh_valid),
    .sh_data    (sh_data),
    .commit     (commit),
    .busy       (busy),
    .frame_err  (frame_err),
    .frame_start(frame_start),
    .row        (row),
    .col        (col)
  );

  always #5 clk = ~clk;

  // Free-running frame position, restarted by reset
  always @(posedge clk) begin
    if (reset) fc <= 0;
    else       fc <= (fc == FRAME - 1) ? 0 : fc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      m_en[p] = 8'h00;
      for (int c = 0; c < C; c++) m_rows[p][c] = 8'h00;
    end
  endtask

  task automatic random_model();
    for (int p = 0; p < NP; p++) begin
      m_en[p] = 8'($urandom);
      for (int c = 0; c < C; c++) m_rows[p][c] = 8'($urandom);
    end
  endtask

  // Serialise the model in shift order: panel 0 first; enables MSB first,
  // then rows of column 0..7, each MSB first.
  function automatic logic [FB-1:0] pack_model();
    logic [FB-1:0] f = '0;
    for (int p = 0; p < NP; p++) begin
      for (int b = C - 1; b >= 0; b--) f = {f[FB-2:0], m_en[p][b]};
      for (int c = 0; c < C; c++)
        for (int b = R - 1; b >= 0; b--) f = {f[FB-2:0], m_rows[p][c][b]};
    end
    return f;
  endfunction

  task automatic expect_model();
    d_en   = m_en;
    d_rows = m_rows;
  endtask

  // Shift nbits of f, MSB first; bits beyond FB are 1. Ends on a negedge.
  task automatic shift_bits(input logic [FB-1:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sh_valid = 1'b1;
      if (i < FB) sh_data = f[FB-1-i];
      else        sh_data = 1'b1;
    end
    @(negedge clk);
    sh_valid = 1'b0;
  endtask

  // Pulse commit for one cycle (optionally with a shift strobe) from a negedge.
  task automatic do_commit(input string tag, input logic with_bit,
                           input logic exp_busy, input logic exp_err);
    commit   = 1'b1;
    sh_valid = with_bit;
    sh_data  = 1'b1;
    @(negedge clk);
    commit   = 1'b0;
    sh_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check({tag, "_err"},  32'(frame_err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_err_clr"}, 32'(frame_err), 32'd0);
  endtask

  task automatic wait_fc(input string tag, input int target);
    int n = 0;
    while (fc != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_align"}, 32'(fc), 32'(target));
  endtask

  task automatic wait_frame_start(input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_fs"}, 32'(frame_start), 32'd1);
    check({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  // Check one whole frame of drive outputs against d_*; busy and
  // frame_start must stay low because nothing is pending.
  task automatic observe_frame(input string tag);
    logic [7:0]  er;
    logic [15:0] ec;
    int s, ph, cc, pp;
    wait_fc(tag, 0);
    for (int m = 0; m < FRAME; m++) begin
      @(negedge clk);
      s  = m / SLOT;
      ph = m % SLOT;
      er = 8'h00;
      ec = 16'h0000;
      if (ph >= BL) begin
        cc = s / NP;
        pp = s % NP;
        er = d_rows[pp][cc];
        ec[pp*C + cc] = d_en[pp][cc];
      end
      check($sformatf("%s_m%0d", tag, m),
            32'({busy, frame_start, row, col}), 32'({2'b00, er, ec}));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    expect_model();

    // 1: reset, then idle -> everything stays zero
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check($sformatf("t1_idle%0d", i),
            32'({busy, frame_start, frame_err, row, col}), 32'd0);
    end

    // 2: two-pixel frame
    clear_model();
    m_en[0] = 8'h01; m_rows[0][0] = 8'hA5;
    m_en[1] = 8'h80; m_rows[1][7] = 8'h3C;
    vec = pack_model();
    shift_bits(vec, FB);
    do_commit("t2_commit", 1'b0, 1'b1, 1'b0);
    wait_frame_start("t2");
    expect_model();
    observe_frame("t2_frame");

    // 3: short and over-long loads are rejected; display unchanged
    random_model();
    vec = pack_model();
    shift_bits(vec, FB - 1);
    do_commit("t3_short", 1'b0, 1'b0, 1'b1);
    shift_bits(vec, FB + 1);
    do_commit("t3_long", 1'b0, 1'b0, 1'b1);
    observe_frame("t3_frame");

    // 4: shifts and a commit while busy are ignored
    random_model();
    vec = pack_model();
    shift_bits(vec, FB);
    wait_fc("t4", 10);
    do_commit("t4_commit", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sh_valid = 1'b1;
      sh_data  = 1'($urandom);
      commit   = (i == 5);
      @(negedge clk);
      check($sformatf("t4_noerr%0d", i), 32'(frame_err), 32'd0);
    end
    sh_valid = 1'b0;
    commit   = 1'b0;
    check("t4_still_busy", 32'(busy), 32'd1);
    wait_frame_start("t4");
    expect_model();
    observe_frame("t4_frame");

    // 5: commit with a same-cycle shift: bit dropped, count restarts
    random_model();
    vec = pack_model();
    shift_bits(vec, FB);
    do_commit("t5_commit", 1'b1, 1'b1, 1'b0);
    wait_frame_start("t5");
    expect_model();
    observe_frame("t5_frame");
    random_model();
    vec = pack_model();
    shift_bits(vec, FB);
    do_commit("t5_recommit", 1'b0, 1'b1, 1'b0);
    wait_frame_start("t5b");
    expect_model();
    observe_frame("t5b_frame");

    // 6: reset mid-DRIVE while busy loses the pending frame
    random_model();
    vec = pack_model();
    shift_bits(vec, FB);
    wait_fc("t6", 10);
    do_commit("t6_commit", 1'b0, 1'b1, 1'b0);
    wait_fc("t6_drive", 40);
    check("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_after_reset", 32'({busy, row, col}), 32'd0);
    reset = 1'b0;
    clear_model();
    expect_model();
    observe_frame("t6_frame");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
